// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_stall_controller_pkg;

  localparam int unsigned CNT_WIDTH_DEF   = 16;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  // Two-bit state encoding shared by the controller and anything that observes it.
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and per-stage freeze/flush controls plus performance counters, bundled as one interface.
// Latency: n/a (wires only).
// Backpressure: n/a; the controller answers every cycle.
interface pipeline_stall_controller_if
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
);
  // Pipeline-side requests.
  logic                 hazard_detected;
  logic                 branch_taken;
  logic                 mem_busy;
  // Per-stage controls.
  logic                 freeze_pc;
  logic                 freeze_if_id;
  logic                 flush_if_id;
  logic                 flush_id_exe;
  logic                 freeze_id_exe;
  logic                 freeze_exe_mem;
  logic                 branch_redirect;
  logic                 mem_timeout;
  // Performance counters.
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;
  logic [CNT_WIDTH-1:0] mem_wait_count;

  // Pipeline / hazard-unit side.
  modport master (
    output hazard_detected, branch_taken, mem_busy,
    input  freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_id_exe,
           freeze_exe_mem, branch_redirect, mem_timeout,
           stall_count, flush_count, mem_wait_count
  );

  // Stall controller side.
  modport slave (
    input  hazard_detected, branch_taken, mem_busy,
    output freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_id_exe,
           freeze_exe_mem, branch_redirect, mem_timeout,
           stall_count, flush_count, mem_wait_count
  );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Latency: count updates one cycle after inc_i.
// Backpressure: none; inc_i is accepted every cycle.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Clear wins; otherwise step by one unless already at all-ones.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Turns load-use hazard, taken branch and MEM busy into per-stage freeze/flush controls, with a MEM watchdog.
// Latency: controls are combinational from state and inputs; counters and state update at the next edge.
// Backpressure: mem_busy freezes every stage; a pending branch/hazard is serviced the cycle it drops.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_stall_controller_if.slave    bus
);

  // Watchdog only has to reach MEM_TIMEOUT; it leaves S_MEM_WAIT before it could go further.
  localparam int unsigned WD_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic freeze_pc_d, freeze_if_id_d, flush_if_id_d, flush_id_exe_d;
  logic freeze_id_exe_d, freeze_exe_mem_d, branch_redirect_d, mem_timeout_d;
  logic stall_inc, flush_inc, mem_wait_inc;

  // State and watchdog registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next state, watchdog and controls: mem_busy beats branch_taken beats hazard_detected.
  always_comb begin
    state_d           = state_q;
    wd_d              = wd_q;
    freeze_pc_d       = 1'b0;
    freeze_if_id_d    = 1'b0;
    flush_if_id_d     = 1'b0;
    flush_id_exe_d    = 1'b0;
    freeze_id_exe_d   = 1'b0;
    freeze_exe_mem_d  = 1'b0;
    branch_redirect_d = 1'b0;
    mem_timeout_d     = 1'b0;
    stall_inc         = 1'b0;
    flush_inc         = 1'b0;
    mem_wait_inc      = 1'b0;

    case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if (bus.mem_busy) begin
          // Whole pipe holds; a pending branch/hazard stays latched in EXE/ID.
          freeze_pc_d      = 1'b1;
          freeze_if_id_d   = 1'b1;
          freeze_id_exe_d  = 1'b1;
          freeze_exe_mem_d = 1'b1;
          mem_wait_inc     = 1'b1;
          if (state_q == S_RUN) begin
            state_d = S_MEM_WAIT;
            wd_d    = WD_W'(1);
          end else if (wd_q == WD_LIMIT) begin
            state_d = S_ERROR;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end else begin
          state_d = S_RUN;
          wd_d    = '0;
          if (bus.branch_taken) begin
            // Instruction in ID is wrong-path, so its hazard is irrelevant.
            branch_redirect_d = 1'b1;
            flush_if_id_d     = 1'b1;
            flush_id_exe_d    = 1'b1;
            flush_inc         = 1'b1;
          end else if (bus.hazard_detected) begin
            freeze_pc_d    = 1'b1;
            freeze_if_id_d = 1'b1;
            flush_id_exe_d = 1'b1;
            stall_inc      = 1'b1;
          end
        end
      end
      S_ERROR: begin
        freeze_pc_d      = 1'b1;
        freeze_if_id_d   = 1'b1;
        freeze_id_exe_d  = 1'b1;
        freeze_exe_mem_d = 1'b1;
        mem_timeout_d    = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        wd_d    = '0;
      end
    endcase

    if (rst) begin
      freeze_pc_d       = 1'b0;
      freeze_if_id_d    = 1'b0;
      flush_if_id_d     = 1'b0;
      flush_id_exe_d    = 1'b0;
      freeze_id_exe_d   = 1'b0;
      freeze_exe_mem_d  = 1'b0;
      branch_redirect_d = 1'b0;
      mem_timeout_d     = 1'b0;
      stall_inc         = 1'b0;
      flush_inc         = 1'b0;
      mem_wait_inc      = 1'b0;
    end
  end

  assign bus.freeze_pc       = freeze_pc_d;
  assign bus.freeze_if_id    = freeze_if_id_d;
  assign bus.flush_if_id     = flush_if_id_d;
  assign bus.flush_id_exe    = flush_id_exe_d;
  assign bus.freeze_id_exe   = freeze_id_exe_d;
  assign bus.freeze_exe_mem  = freeze_exe_mem_d;
  assign bus.branch_redirect = branch_redirect_d;
  assign bus.mem_timeout     = mem_timeout_d;

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .clear_i(rst), .inc_i(stall_inc), .count_o(bus.stall_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .clear_i(rst), .inc_i(flush_inc), .count_o(bus.flush_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_mem_wait_cnt (
    .clk(clk), .clear_i(rst), .inc_i(mem_wait_inc), .count_o(bus.mem_wait_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench for pipeline_stall_controller: two instances (default-size and tiny-parameter).
// Latency: expected values pushed per cycle, checked on the falling edge of the same cycle.
// Backpressure: n/a.
module tb_pipeline_stall_controller;

  // Control bit order: freeze_pc, freeze_if_id, flush_if_id, flush_id_exe,
  //                    freeze_id_exe, freeze_exe_mem, branch_redirect, mem_timeout
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_HAZ  = 8'b1101_0000;
  localparam logic [7:0] C_BR   = 8'b0011_0010;
  localparam logic [7:0] C_MEM  = 8'b1100_1100;
  localparam logic [7:0] C_ERR  = 8'b1100_1101;

  typedef struct {
    int          idx;
    bit          sel;   // 0: instance A, 1: instance B
    logic [7:0]  ctrl;
    logic [15:0] stall;
    logic [15:0] flush;
    logic [15:0] mwait;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  exp_t sb[$];
  int   n_checks;
  int   n_errors;
  int   vec_no;

  pipeline_stall_controller_if #(.CNT_WIDTH(16)) if_a ();
  pipeline_stall_controller_if #(.CNT_WIDTH(2))  if_b ();

  pipeline_stall_controller #(.CNT_WIDTH(16), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst_a), .bus(if_a.slave)
  );

  pipeline_stall_controller #(.CNT_WIDTH(2), .MEM_TIMEOUT(3)) dut_b (
    .clk(clk), .rst(rst_b), .bus(if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus to the selected instance (other held in reset) and queue its expectation.
  task automatic apply(input bit sel, input bit r, input bit hz, input bit br, input bit mb,
                       input logic [7:0] ctrl, input int s, input int f, input int w);
    exp_t e;
    @(posedge clk);
    #1;
    if (!sel) begin
      rst_a = r;  if_a.hazard_detected = hz; if_a.branch_taken = br; if_a.mem_busy = mb;
      rst_b = 1'b1; if_b.hazard_detected = 1'b0; if_b.branch_taken = 1'b0; if_b.mem_busy = 1'b0;
    end else begin
      rst_b = r;  if_b.hazard_detected = hz; if_b.branch_taken = br; if_b.mem_busy = mb;
      rst_a = 1'b1; if_a.hazard_detected = 1'b0; if_a.branch_taken = 1'b0; if_a.mem_busy = 1'b0;
    end
    vec_no  = vec_no + 1;
    e.idx   = vec_no;
    e.sel   = sel;
    e.ctrl  = ctrl;
    e.stall = 16'(s);
    e.flush = 16'(f);
    e.mwait = 16'(w);
    sb.push_back(e);
  endtask

  // Monitor: every falling edge with an outstanding expectation, compare the selected instance.
  initial begin
    exp_t        e;
    logic [7:0]  act_ctrl;
    logic [47:0] act_cnt;
    logic [47:0] exp_cnt;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.sel) begin
          act_ctrl = {if_a.freeze_pc, if_a.freeze_if_id, if_a.flush_if_id, if_a.flush_id_exe,
                      if_a.freeze_id_exe, if_a.freeze_exe_mem, if_a.branch_redirect, if_a.mem_timeout};
          act_cnt  = {if_a.stall_count, if_a.flush_count, if_a.mem_wait_count};
        end else begin
          act_ctrl = {if_b.freeze_pc, if_b.freeze_if_id, if_b.flush_if_id, if_b.flush_id_exe,
                      if_b.freeze_id_exe, if_b.freeze_exe_mem, if_b.branch_redirect, if_b.mem_timeout};
          act_cnt  = {14'd0, if_b.stall_count, 14'd0, if_b.flush_count, 14'd0, if_b.mem_wait_count};
        end
        exp_cnt = {e.stall, e.flush, e.mwait};
        n_checks = n_checks + 1;
        if (act_ctrl !== e.ctrl) begin
          n_errors = n_errors + 1;
          $display("FAIL vec%0d ctrl: got %b expected %b", e.idx, act_ctrl, e.ctrl);
        end
        n_checks = n_checks + 1;
        if (act_cnt !== exp_cnt) begin
          n_errors = n_errors + 1;
          $display("FAIL vec%0d counters(stall/flush/memwait): got %0d/%0d/%0d expected %0d/%0d/%0d",
                   e.idx, act_cnt[47:32], act_cnt[31:16], act_cnt[15:0], e.stall, e.flush, e.mwait);
        end
      end
    end
  end

  // Stimulus: directed vectors; sel r hz br mb | ctrl stall flush memwait (counters seen before this edge).
  initial begin
    n_checks = 0;
    n_errors = 0;
    vec_no   = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    if_a.hazard_detected = 1'b0; if_a.branch_taken = 1'b0; if_a.mem_busy = 1'b0;
    if_b.hazard_detected = 1'b0; if_b.branch_taken = 1'b0; if_b.mem_busy = 1'b0;
    @(posedge clk);
    @(posedge clk);

    // ---- Instance A: CNT_WIDTH=16, MEM_TIMEOUT=255 ----
    apply(0, 1, 1, 1, 1, C_NONE, 0, 0, 0);  // reset with all inputs high
    apply(0, 1, 1, 1, 1, C_NONE, 0, 0, 0);
    apply(0, 0, 0, 0, 0, C_NONE, 0, 0, 0);
    apply(0, 0, 1, 0, 0, C_HAZ,  0, 0, 0);  // load-use bubble
    apply(0, 0, 0, 0, 0, C_NONE, 1, 0, 0);
    apply(0, 0, 1, 1, 0, C_BR,   1, 0, 0);  // branch beats hazard
    apply(0, 0, 0, 0, 0, C_NONE, 1, 1, 0);
    apply(0, 0, 0, 1, 1, C_MEM,  1, 1, 0);  // 4 busy cycles, branch held
    apply(0, 0, 0, 1, 1, C_MEM,  1, 1, 1);
    apply(0, 0, 0, 1, 1, C_MEM,  1, 1, 2);
    apply(0, 0, 0, 1, 1, C_MEM,  1, 1, 3);
    apply(0, 0, 0, 1, 0, C_BR,   1, 1, 4);  // branch serviced as busy drops
    apply(0, 0, 0, 0, 0, C_NONE, 1, 2, 4);
    apply(0, 0, 1, 0, 1, C_MEM,  1, 2, 4);  // busy beats hazard, no stall count
    apply(0, 0, 0, 0, 0, C_NONE, 1, 2, 5);
    apply(0, 0, 0, 0, 1, C_MEM,  1, 2, 5);
    apply(0, 1, 0, 0, 1, C_NONE, 1, 2, 6);  // reset mid-wait
    apply(0, 0, 0, 0, 0, C_NONE, 0, 0, 0);
    apply(0, 0, 1, 0, 0, C_HAZ,  0, 0, 0);  // back in S_RUN

    // ---- Instance B: CNT_WIDTH=2, MEM_TIMEOUT=3 ----
    apply(1, 0, 0, 0, 0, C_NONE, 0, 0, 0);
    apply(1, 0, 1, 0, 0, C_HAZ,  0, 0, 0);  // 5 hazards, saturate at 3
    apply(1, 0, 1, 0, 0, C_HAZ,  1, 0, 0);
    apply(1, 0, 1, 0, 0, C_HAZ,  2, 0, 0);
    apply(1, 0, 1, 0, 0, C_HAZ,  3, 0, 0);
    apply(1, 0, 1, 0, 0, C_HAZ,  3, 0, 0);
    apply(1, 0, 0, 0, 0, C_NONE, 3, 0, 0);
    apply(1, 0, 0, 0, 1, C_MEM,  3, 0, 0);  // busy exactly MEM_TIMEOUT cycles
    apply(1, 0, 0, 0, 1, C_MEM,  3, 0, 1);
    apply(1, 0, 0, 0, 1, C_MEM,  3, 0, 2);
    apply(1, 0, 0, 0, 0, C_NONE, 3, 0, 3);  // no error
    apply(1, 0, 1, 0, 0, C_HAZ,  3, 0, 3);
    apply(1, 0, 0, 0, 1, C_MEM,  3, 0, 3);  // busy MEM_TIMEOUT+1 cycles
    apply(1, 0, 0, 0, 1, C_MEM,  3, 0, 3);
    apply(1, 0, 0, 0, 1, C_MEM,  3, 0, 3);
    apply(1, 0, 0, 0, 1, C_MEM,  3, 0, 3);
    apply(1, 0, 0, 0, 0, C_ERR,  3, 0, 3);  // sticky error
    apply(1, 0, 0, 1, 0, C_ERR,  3, 0, 3);  // branch ignored, counters frozen
    apply(1, 0, 1, 0, 0, C_ERR,  3, 0, 3);
    apply(1, 1, 0, 0, 0, C_NONE, 3, 0, 3);  // only reset exits
    apply(1, 0, 0, 0, 0, C_NONE, 0, 0, 0);

    // Drain: bounded wait for the monitor to consume everything.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      n_checks = n_checks + 1;
      n_errors = n_errors + 1;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
